control_pipe_unit: RTL
======================

CONTROL_PIPE_UNIT -- requirements
Module: control_pipe_unit

Interface
REQ-001 Parameter OPW, default 6, opcode width.
REQ-002 Parameter RAW, default 5, register-address width.
REQ-003 Parameter CNTW, default 16, stall/flush counter width.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  pipeline advance enable; 0 holds all registers.
REQ-007 opcode_id  input  OPW  opcode of instruction in ID.
REQ-008 rs_id, rt_id  input  RAW each  source register fields in ID.
REQ-009 flush_ex  input  1  branch taken, resolved in EX; discard ID instruction.
REQ-010 cw_id  output  11  combinational decoded word {RegDst, ALUSrc, ALUOp[1:0], Branch, MemRead, MemWrite, MemtoReg, RegWrite, Jal, BrNe}.
REQ-011 jump_id  output  1  combinational, opcode is J or JAL.
REQ-012 illegal_id  output  1  combinational, opcode not decoded.
REQ-013 stall  output  1  combinational load-use hold request to PC and IF/ID.
REQ-014 ex_cw, mem_cw, wb_cw  output  11 each  registered control words per stage.
REQ-015 illegal_seen  output  1  sticky illegal-opcode flag.
REQ-016 stall_cnt, flush_cnt  output  CNTW each  saturating event counters.

Function
REQ-017 Decode table (word bits MSB first): R=0 -> 1,0,10,0,0,0,0,1,0,0; J=2 -> 0,0,01,0,0,0,0,0,0,0; JAL=3 -> 1,0,01,0,0,0,0,1,1,0; BEQ=4 -> 0,0,01,1,0,0,0,0,0,0; BNE=5 -> 0,0,01,1,0,0,0,0,0,1; ADDI=8 -> 0,1,00,0,0,0,0,1,0,0; SLTI=18 -> 0,1,11,0,0,0,0,1,0,0; LW=35 -> 0,1,00,0,1,0,1,1,0,0; SW=43 -> 0,1,00,0,0,1,0,0,0,0.
REQ-018 Any other opcode SHALL decode to all-zero word, jump_id=0, illegal_id=1; no X on any output.
REQ-019 Don't-care fields SHALL be driven 0.
REQ-020 Hazard = ex_cw.MemRead & ex_rt!=0 & (ex_rt==rs_id | (ex_rt==rt_id & opcode_id in {R,BEQ,BNE,SW})), ex_rt being rt registered with ex_cw.
REQ-021 stall SHALL equal hazard & ~flush_ex.
REQ-022 On each edge with en=1: wb_cw<=mem_cw, mem_cw<=ex_cw.
REQ-023 On same edge: ex_cw<=0 and ex_rt<=0 if flush_ex or stall; else ex_cw<=cw_id, ex_rt<=rt_id.
REQ-024 Latency: word decoded in ID before edge N appears on ex_cw after N, mem_cw after N+1, wb_cw after N+2.
REQ-025 flush_ex and hazard together: flush wins, bubble inserted, stall=0, flush_cnt increments, stall_cnt not.
REQ-026 stall_cnt SHALL increment on each enabled edge with stall=1; flush_cnt on each enabled edge with flush_ex=1.
REQ-027 Counters SHALL saturate at all-ones, no wrap.
REQ-028 illegal_seen SHALL set on enabled edge with illegal_id=1 and not flush_ex; clears only by reset.
REQ-029 en=0 SHALL freeze all registers and counters; combinational outputs still track inputs.

Reset
REQ-030 rst_n=0 SHALL immediately clear ex_cw, mem_cw, wb_cw, ex_rt, stall_cnt, flush_cnt, illegal_seen to 0, independent of clk.
REQ-031 Reset mid-stream SHALL discard all in-flight words; first edge after release loads cw_id normally.

Verification
REQ-032 Sequence R, LW, SW, BEQ, JAL, en=1 -> cw_id per REQ-017; each word on wb_cw exactly 3 edges after issue.
REQ-033 LW rt=8 then R rs=8 -> stall=1 one cycle, ex_cw=0 bubble, stall_cnt=1, R enters EX next edge.
REQ-034 LW rt=0 then R rs=0 -> stall=0; LW rt=8 then ADDI rt=8 (rs=3) -> stall=0.
REQ-035 Hazard plus flush_ex=1 same cycle -> stall=0, ex_cw=0, flush_cnt=1, stall_cnt=0.
REQ-036 opcode 63 -> illegal_id=1, cw_id=0, illegal_seen=1 after edge; CNTW=2 with 5 stalls -> stall_cnt=3.
REQ-037 rst_n low between edges with nonzero pipeline -> all registered outputs 0 before next edge.

Source files
------------

// File: rtl/control_pipe_unit.sv
// Control path for a 5-stage pipeline: ID decoder, load-use hazard detection,
// EX/MEM/WB control-word registers and saturating stall/flush event counters.
module control_pipe_unit #(
  parameter int OPW  = 6,
  parameter int RAW  = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [OPW-1:0]  opcode_id,
  input  logic [RAW-1:0]  rs_id,
  input  logic [RAW-1:0]  rt_id,
  input  logic            flush_ex,
  output logic [10:0]     cw_id,
  output logic            jump_id,
  output logic            illegal_id,
  output logic            stall,
  output logic [10:0]     ex_cw,
  output logic [10:0]     mem_cw,
  output logic [10:0]     wb_cw,
  output logic            illegal_seen,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  localparam int CW_W       = 11;
  localparam int CW_MEMREAD = 5;

  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_J    = OPW'(2);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(3);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(4);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(5);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(8);
  localparam logic [OPW-1:0] OP_SLTI = OPW'(18);
  localparam logic [OPW-1:0] OP_LW   = OPW'(35);
  localparam logic [OPW-1:0] OP_SW   = OPW'(43);

  // {RegDst, ALUSrc, ALUOp[1:0], Branch, MemRead, MemWrite, MemtoReg, RegWrite, Jal, BrNe}
  localparam logic [CW_W-1:0] CW_R    = 11'b1_0_10_0_0_0_0_1_0_0;
  localparam logic [CW_W-1:0] CW_J    = 11'b0_0_01_0_0_0_0_0_0_0;
  localparam logic [CW_W-1:0] CW_JAL  = 11'b1_0_01_0_0_0_0_1_1_0;
  localparam logic [CW_W-1:0] CW_BEQ  = 11'b0_0_01_1_0_0_0_0_0_0;
  localparam logic [CW_W-1:0] CW_BNE  = 11'b0_0_01_1_0_0_0_0_0_1;
  localparam logic [CW_W-1:0] CW_ADDI = 11'b0_1_00_0_0_0_0_1_0_0;
  localparam logic [CW_W-1:0] CW_SLTI = 11'b0_1_11_0_0_0_0_1_0_0;
  localparam logic [CW_W-1:0] CW_LW   = 11'b0_1_00_0_1_0_1_1_0_0;
  localparam logic [CW_W-1:0] CW_SW   = 11'b0_1_00_0_0_1_0_0_0_0;

  logic [CW_W-1:0] cw_p1;
  logic [CW_W-1:0] cw_p2;
  logic [CW_W-1:0] cw_p3;
  logic [RAW-1:0]  rt_p1;
  logic            uses_rt;
  logic            hazard;
  logic            bubble;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (&c) ? c : c + CNTW'(1);
  endfunction

  // ID stage: decode; uses_rt marks formats that read rt as a source operand
  always_comb begin
    cw_id      = '0;
    jump_id    = 1'b0;
    illegal_id = 1'b0;
    uses_rt    = 1'b0;
    case (opcode_id)
      OP_R:    begin cw_id = CW_R;   uses_rt = 1'b1; end
      OP_J:    begin cw_id = CW_J;   jump_id = 1'b1; end
      OP_JAL:  begin cw_id = CW_JAL; jump_id = 1'b1; end
      OP_BEQ:  begin cw_id = CW_BEQ; uses_rt = 1'b1; end
      OP_BNE:  begin cw_id = CW_BNE; uses_rt = 1'b1; end
      OP_ADDI: cw_id = CW_ADDI;
      OP_SLTI: cw_id = CW_SLTI;
      OP_LW:   cw_id = CW_LW;
      OP_SW:   begin cw_id = CW_SW;  uses_rt = 1'b1; end
      default: illegal_id = 1'b1;
    endcase
  end

  assign hazard = cw_p1[CW_MEMREAD] && (rt_p1 != '0) &&
                  ((rt_p1 == rs_id) || ((rt_p1 == rt_id) && uses_rt));
  // A taken branch discards the ID instruction anyway, so it overrides the stall
  assign stall  = hazard & ~flush_ex;
  assign bubble = flush_ex | stall;

  // ID -> EX -> MEM -> WB boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_p1 <= '0;
      cw_p2 <= '0;
      cw_p3 <= '0;
      rt_p1 <= '0;
    end else if (en) begin
      cw_p3 <= cw_p2;
      cw_p2 <= cw_p1;
      cw_p1 <= bubble ? '0 : cw_id;
      rt_p1 <= bubble ? '0 : rt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      illegal_seen <= 1'b0;
    end else if (en) begin
      if (stall)
        stall_cnt <= sat_inc(stall_cnt);
      if (flush_ex)
        flush_cnt <= sat_inc(flush_cnt);
      if (illegal_id && !flush_ex)
        illegal_seen <= 1'b1;
    end
  end

  assign ex_cw  = cw_p1;
  assign mem_cw = cw_p2;
  assign wb_cw  = cw_p3;

endmodule
